// File: rtl/pll_phase_responder.sv
// PLL-side partner of the dynamic phase-shift handshake: synchronizes the scan
// interface, runs the phasestep/phase_done protocol and tracks per-counter phases.
module pll_phase_responder #(
  parameter int PHASE_STEPS  = 24,
  parameter int PHASE_W      = 5,
  parameter int DONE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   areset,
  input  logic                   scanclk,
  input  logic                   phasestep,
  input  logic [2:0]             phasecounterselect,
  input  logic                   phaseupdown,
  output logic                   phase_done,
  output logic [6*PHASE_W-1:0]   phase_cnt,
  output logic [15:0]            step_total,
  output logic                   err_badsel,
  output logic                   err_short
);

  localparam int LAT_W = (DONE_LATENCY > 1) ? $clog2(DONE_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, BUSY, RELEASE} state_t;

  logic [1:0]       scan_s, step_s, ud_s, ar_s;
  logic [2:0]       sel_s0, sel_s1;
  logic             scan_d;
  logic             scan_rise;
  state_t           state;
  logic [2:0]       lat_sel;
  logic             lat_up;
  logic [LAT_W-1:0] lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_s <= '0;
      step_s <= '0;
      ud_s   <= '0;
      ar_s   <= '0;
      sel_s0 <= '0;
      sel_s1 <= '0;
      scan_d <= 1'b0;
    end else begin
      scan_s <= {scan_s[0], scanclk};
      step_s <= {step_s[0], phasestep};
      ud_s   <= {ud_s[0], phaseupdown};
      ar_s   <= {ar_s[0], areset};
      sel_s0 <= phasecounterselect;
      sel_s1 <= sel_s0;
      scan_d <= scan_s[1];
    end
  end

  assign scan_rise = scan_s[1] & ~scan_d;

  function automatic logic [PHASE_W-1:0] step_phase(input logic [PHASE_W-1:0] p,
                                                    input logic up);
    if (up)
      return (p == PHASE_W'(PHASE_STEPS - 1)) ? '0 : p + PHASE_W'(1);
    else
      return (p == '0) ? PHASE_W'(PHASE_STEPS - 1) : p - PHASE_W'(1);
  endfunction

  // Synced areset behaves exactly like reset_n and overrides any step in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase_done <= 1'b1;
      phase_cnt  <= '0;
      step_total <= '0;
      err_badsel <= 1'b0;
      err_short  <= 1'b0;
      lat_sel    <= '0;
      lat_up     <= 1'b0;
      lat        <= '0;
    end else if (ar_s[1]) begin
      state      <= IDLE;
      phase_done <= 1'b1;
      phase_cnt  <= '0;
      step_total <= '0;
      err_badsel <= 1'b0;
      err_short  <= 1'b0;
      lat_sel    <= '0;
      lat_up     <= 1'b0;
      lat        <= '0;
    end else begin
      err_short <= 1'b0;
      if (scan_rise) begin
        case (state)
          IDLE: begin
            if (step_s[1]) begin
              lat_sel <= sel_s1;
              lat_up  <= ud_s[1];
              state   <= ARMED;
            end
          end
          ARMED: begin
            if (step_s[1]) begin
              phase_done <= 1'b0;
              lat        <= '0;
              state      <= BUSY;
            end else begin
              err_short <= 1'b1;
              state     <= IDLE;
            end
          end
          BUSY: begin
            if (lat == LAT_W'(DONE_LATENCY - 1)) begin
              // Select 000 hits every slice, 001..110 one slice, 111 none.
              for (int i = 0; i < 6; i++) begin
                if (lat_sel == 3'd0 || lat_sel == 3'(i + 1))
                  phase_cnt[i*PHASE_W +: PHASE_W] <=
                    step_phase(phase_cnt[i*PHASE_W +: PHASE_W], lat_up);
              end
              if (lat_sel == 3'd7)
                err_badsel <= 1'b1;
              if (step_total != 16'hFFFF)
                step_total <= step_total + 16'd1;
              phase_done <= 1'b1;
              state      <= RELEASE;
            end else begin
              lat <= lat + LAT_W'(1);
            end
          end
          RELEASE: begin
            if (!step_s[1])
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_responder.sv
// Randomized scoreboard bench for pll_phase_responder: a phase-arithmetic model
// predicts each completed step, a monitor checks it when phase_done re-asserts.
module tb_pll_phase_responder;

  localparam int PHASE_STEPS  = 24;
  localparam int PHASE_W      = 5;
  localparam int DONE_LATENCY = 2;
  localparam int HALF_SCAN    = 6;

  typedef struct {
    logic [6*PHASE_W-1:0] cnt;
    logic [15:0]          tot;
    logic                 bad;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 areset = 1'b0;
  logic                 scanclk = 1'b0;
  logic                 phasestep = 1'b0;
  logic [2:0]           phasecounterselect = '0;
  logic                 phaseupdown = 1'b0;
  logic                 phase_done;
  logic [6*PHASE_W-1:0] phase_cnt;
  logic [15:0]          step_total;
  logic                 err_badsel;
  logic                 err_short;

  int   errors = 0;
  int   checks = 0;
  int   ph [6];
  int   total = 0;
  bit   badsel = 0;
  int   shorts_exp = 0;
  int   shorts_seen = 0;
  bit   ignore_done = 0;
  exp_t sb [$];

  pll_phase_responder #(
    .PHASE_STEPS(PHASE_STEPS), .PHASE_W(PHASE_W), .DONE_LATENCY(DONE_LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .areset(areset), .scanclk(scanclk),
    .phasestep(phasestep), .phasecounterselect(phasecounterselect),
    .phaseupdown(phaseupdown), .phase_done(phase_done), .phase_cnt(phase_cnt),
    .step_total(step_total), .err_badsel(err_badsel), .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [6*PHASE_W-1:0] pack_model();
    logic [6*PHASE_W-1:0] v = '0;
    for (int i = 0; i < 6; i++) v[i*PHASE_W +: PHASE_W] = PHASE_W'(ph[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) ph[i] = 0;
    total  = 0;
    badsel = 0;
  endfunction

  // Reference step: modular phase arithmetic on the addressed counters.
  function automatic void model_step(input int sel, input bit up);
    exp_t e;
    if (sel == 7) badsel = 1;
    for (int i = 0; i < 6; i++)
      if (sel == 0 || sel == i + 1)
        ph[i] = up ? (ph[i] + 1) % PHASE_STEPS : (ph[i] + PHASE_STEPS - 1) % PHASE_STEPS;
    if (total < 16'hFFFF) total++;
    e.cnt = pack_model();
    e.tot = 16'(total);
    e.bad = badsel;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_cycle();
    tick(HALF_SCAN);
    scanclk = 1'b1;
    tick(HALF_SCAN);
    scanclk = 1'b0;
  endtask

  // One request: phasestep held for 'hold' scanclk rises, then dropped until idle.
  task automatic apply_stimulus(input int sel, input bit up, input int hold);
    int extra;
    if (hold >= 2) model_step(sel, up);
    else shorts_exp++;
    phasestep          = 1'b1;
    phasecounterselect = 3'(sel);
    phaseupdown        = up;
    for (int r = 1; r <= hold; r++) begin
      scan_cycle();
      if (r == 1) begin
        phasecounterselect = 3'($urandom_range(7));
        phaseupdown        = 1'($urandom_range(1));
      end
    end
    phasestep = 1'b0;
    extra = (hold >= 2 + DONE_LATENCY) ? 1 : (2 + DONE_LATENCY - hold) + 1;
    repeat (extra) scan_cycle();
  endtask

  task automatic pulse_areset();
    ignore_done = 1;
    areset = 1'b1;
    tick(8);
    model_reset();
    areset = 1'b0;
    tick(8);
    ignore_done = 0;
  endtask

  // Monitor: completion is signalled by phase_done re-asserting.
  initial begin : monitor
    logic prev_done = 1'b1;
    logic prev_scan = 1'b0;
    bit   tracking  = 0;
    int   rises     = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (err_short) shorts_seen++;
      if (tracking && scanclk && !prev_scan) rises++;
      if (!phase_done && prev_done) begin
        tracking = 1;
        rises    = 0;
      end
      if (phase_done && !prev_done) begin
        if (ignore_done) begin
          tracking = 0;
        end else begin
          check_output("done_latency_rises", rises, DONE_LATENCY);
          tracking = 0;
          if (sb.size() == 0) begin
            check_output("unexpected_completion", 1, 0);
          end else begin
            e = sb.pop_front();
            check_output("phase_cnt", 32'(phase_cnt), 32'(e.cnt));
            check_output("step_total", 32'(step_total), 32'(e.tot));
            check_output("err_badsel", 32'(err_badsel), 32'(e.bad));
          end
        end
      end
      prev_done = phase_done;
      prev_scan = scanclk;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    model_reset();
    tick(5);
    reset_n = 1'b1;
    tick(5);
    check_output("reset_phase_done", 32'(phase_done), 1);
    check_output("reset_phase_cnt", 32'(phase_cnt), 0);
    check_output("reset_step_total", 32'(step_total), 0);
    check_output("reset_err_badsel", 32'(err_badsel), 0);

    apply_stimulus(2, 1'b1, 3);
    check_output("c0_single_step", 32'(phase_cnt), 32'(pack_model()));

    pulse_areset();
    apply_stimulus(0, 1'b0, 3);
    check_output("all_down_wrap", 32'(phase_cnt), 32'(pack_model()));
    for (int k = 0; k < PHASE_STEPS; k++) apply_stimulus(0, 1'b1, 2 + (k % 3));
    check_output("all_up_full_wrap", 32'(phase_cnt), 32'(pack_model()));
    check_output("total_after_wrap", 32'(step_total), 25);

    apply_stimulus(3, 1'b1, 1);
    check_output("short_no_change", 32'(phase_cnt), 32'(pack_model()));
    check_output("short_total", 32'(step_total), 32'(total));
    check_output("short_pulses", shorts_seen, shorts_exp);
    apply_stimulus(4, 1'b0, 10);
    check_output("held_one_step", 32'(step_total), 32'(total));

    apply_stimulus(7, 1'b1, 3);
    check_output("badsel_set", 32'(err_badsel), 1);
    check_output("badsel_done", 32'(phase_done), 1);
    pulse_areset();
    check_output("areset_badsel", 32'(err_badsel), 0);
    check_output("areset_cnt", 32'(phase_cnt), 0);
    check_output("areset_total", 32'(step_total), 0);

    apply_stimulus(1, 1'b1, 3);
    phasestep = 1'b1;
    phasecounterselect = 3'd5;
    phaseupdown = 1'b1;
    scan_cycle();
    scan_cycle();
    check_output("busy_done_low", 32'(phase_done), 0);
    ignore_done = 1;
    areset = 1'b1;
    tick(8);
    model_reset();
    phasestep = 1'b0;
    check_output("areset_busy_done", 32'(phase_done), 1);
    check_output("areset_busy_cnt", 32'(phase_cnt), 0);
    check_output("areset_busy_total", 32'(step_total), 0);
    areset = 1'b0;
    tick(8);
    ignore_done = 0;
    scan_cycle();
    apply_stimulus(6, 1'b0, 3);

    for (int k = 0; k < 20; k++) begin
      int holds [4] = '{1, 2, 3, 5};
      apply_stimulus(int'($urandom_range(7)), 1'($urandom_range(1)),
                     holds[$urandom_range(3)]);
    end
    tick(20);
    check_output("final_cnt", 32'(phase_cnt), 32'(pack_model()));
    check_output("final_short_pulses", shorts_seen, shorts_exp);
    check_output("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
